// File: rtl/dpll_search_ctrl_pkg.sv
// Shared types for the DPLL search slice: literals, clauses, formulas, trail entries.
// Formula is a fixed grid of clause slots; a literal with id 0 marks an empty slot.
package dpll_search_ctrl_pkg;

  localparam int VAR_W   = 4;
  localparam int CL_LITS = 3;
  localparam int NUM_CL  = 4;

  typedef struct packed {
    logic             neg;
    logic [VAR_W-1:0] id;
  } lit_t;

  typedef lit_t  [CL_LITS-1:0] clause_t;
  typedef clause_t [NUM_CL-1:0] formula_t;

  typedef struct packed {
    formula_t f;
    lit_t     l;
    logic     flipped;
  } trail_entry_t;

  localparam lit_t     ZERO_LIT     = '0;
  localparam formula_t ZERO_FORMULA = '0;

  function automatic lit_t lit_neg(lit_t l);
    lit_t r;
    r     = l;
    r.neg = ~l.neg;
    return r;
  endfunction

  // Row-major scan: the first occupied slot is the first literal of the
  // lowest-index non-empty clause.
  function automatic lit_t pick_lit(formula_t f);
    lit_t r;
    logic found;
    r     = ZERO_LIT;
    found = 1'b0;
    for (int c = 0; c < NUM_CL; c++)
      for (int k = 0; k < CL_LITS; k++)
        if (!found && f[c][k].id != '0) begin
          r     = f[c][k];
          found = 1'b1;
        end
    return r;
  endfunction

endpackage

// File: rtl/dpll_search_ctrl_trail_stack.sv
// Chronological-backtracking trail: LIFO of trail_entry_t with in-place flip of the top.
// One operation per cycle; clear has priority, then push, pop, flip_top.
module dpll_trail_stack
  import dpll_search_ctrl_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  trail_entry_t push_entry,
  input  logic         pop,
  input  logic         flip_top,
  output trail_entry_t top,
  output logic         empty,
  output logic         full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  trail_entry_t  mem [DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] top_c;
  logic [IW-1:0] top_i;
  logic [IW-1:0] wr_i;

  assign top_c = count - CW'(1);
  assign top_i = top_c[IW-1:0];
  assign wr_i  = count[IW-1:0];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign top   = mem[top_i];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push && !full) begin
      mem[wr_i] <= push_entry;
      count     <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end else if (flip_top && !empty) begin
      mem[top_i].l       <= lit_neg(mem[top_i].l);
      mem[top_i].flipped <= 1'b1;
    end
  end

endmodule

// File: rtl/dpll_search_ctrl.sv
// DPLL search sequencer: alternates simplification and branching, backtracks via the trail.
// Optional statistics counters built only when DPLL_STATS_EN is defined.
module dpll_search_ctrl
  import dpll_search_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  formula_t         in_formula,
  output logic             busy,
  output logic             done,
  output logic             sat,
  output logic             unsat,
  output logic             ovf,
  output logic             dec_valid,
  output lit_t             dec_lit,
  output logic             kern_find,
  output formula_t         kern_formula,
  input  logic             kern_ended,
  input  logic             kern_sat,
  input  logic             kern_unsat,
  input  formula_t         kern_out,
  output logic             asg_find,
  output formula_t         asg_formula,
  output lit_t             asg_lit,
  input  logic             asg_ended,
  input  logic             asg_empty_formula,
  input  logic             asg_empty_clause,
  input  formula_t         asg_out,
  output logic [CNT_W-1:0] n_dec,
  output logic [CNT_W-1:0] n_confl
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SIMP_REQ  = 3'd1;
  localparam logic [2:0] S_SIMP_WAIT = 3'd2;
  localparam logic [2:0] S_DECIDE    = 3'd3;
  localparam logic [2:0] S_ASG_REQ   = 3'd4;
  localparam logic [2:0] S_ASG_WAIT  = 3'd5;
  localparam logic [2:0] S_BACKTRACK = 3'd6;
  localparam logic [2:0] S_FINISH    = 3'd7;

  logic [2:0]   state;
  formula_t     cur;
  lit_t         pick, flip_lit;
  trail_entry_t stk_top, push_entry;
  logic         stk_empty, stk_full;
  logic         stk_clear, stk_push, stk_pop, stk_flip;

  assign pick       = pick_lit(cur);
  assign flip_lit   = lit_neg(stk_top.l);
  assign push_entry = '{f: cur, l: pick, flipped: 1'b0};

  assign stk_clear = (state == S_IDLE) && start;
  assign stk_push  = (state == S_DECIDE) && !stk_full;
  assign stk_pop   = (state == S_BACKTRACK) && !stk_empty && stk_top.flipped;
  assign stk_flip  = (state == S_BACKTRACK) && !stk_empty && !stk_top.flipped;

  dpll_trail_stack #(.DEPTH(DEPTH)) u_trail (
    .clock      (clock),
    .reset      (reset),
    .clear      (stk_clear),
    .push       (stk_push),
    .push_entry (push_entry),
    .pop        (stk_pop),
    .flip_top   (stk_flip),
    .top        (stk_top),
    .empty      (stk_empty),
    .full       (stk_full)
  );

  // Requests and done are pure state decodes so they last exactly one cycle.
  assign kern_find    = (state == S_SIMP_REQ);
  assign asg_find     = (state == S_ASG_REQ);
  assign done         = (state == S_FINISH);
  assign kern_formula = cur;
  assign asg_formula  = cur;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cur       <= ZERO_FORMULA;
      busy      <= 1'b0;
      sat       <= 1'b0;
      unsat     <= 1'b0;
      ovf       <= 1'b0;
      dec_valid <= 1'b0;
      dec_lit   <= ZERO_LIT;
      asg_lit   <= ZERO_LIT;
    end else begin
      dec_valid <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          cur   <= in_formula;
          sat   <= 1'b0;
          unsat <= 1'b0;
          ovf   <= 1'b0;
          busy  <= 1'b1;
          state <= S_SIMP_REQ;
        end
        S_SIMP_REQ: state <= S_SIMP_WAIT;
        S_SIMP_WAIT: if (kern_ended) begin
          if (kern_sat) begin
            sat   <= 1'b1;
            state <= S_FINISH;
          end else if (kern_unsat) begin
            state <= S_BACKTRACK;
          end else begin
            cur   <= kern_out;
            state <= S_DECIDE;
          end
        end
        S_DECIDE: if (stk_full) begin
          ovf   <= 1'b1;
          state <= S_FINISH;
        end else begin
          dec_valid <= 1'b1;
          dec_lit   <= pick;
          asg_lit   <= pick;
          state     <= S_ASG_REQ;
        end
        S_ASG_REQ: state <= S_ASG_WAIT;
        S_ASG_WAIT: if (asg_ended) begin
          if (asg_empty_formula) begin
            sat   <= 1'b1;
            state <= S_FINISH;
          end else if (asg_empty_clause) begin
            state <= S_BACKTRACK;
          end else begin
            cur   <= asg_out;
            state <= S_SIMP_REQ;
          end
        end
        S_BACKTRACK: if (stk_empty) begin
          unsat <= 1'b1;
          state <= S_FINISH;
        end else if (!stk_top.flipped) begin
          // Popping already-flipped entries keeps us here, one per cycle.
          cur       <= stk_top.f;
          dec_valid <= 1'b1;
          dec_lit   <= flip_lit;
          asg_lit   <= flip_lit;
          state     <= S_ASG_REQ;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DPLL_STATS_EN
  logic             bt_enter;
  logic [CNT_W-1:0] dec_q, confl_q;

  assign bt_enter = ((state == S_SIMP_WAIT) && kern_ended && !kern_sat && kern_unsat) ||
                    ((state == S_ASG_WAIT) && asg_ended && !asg_empty_formula && asg_empty_clause);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dec_q   <= '0;
      confl_q <= '0;
    end else if (stk_clear) begin
      dec_q   <= '0;
      confl_q <= '0;
    end else begin
      if ((stk_push || stk_flip) && dec_q != '1) dec_q <= dec_q + CNT_W'(1);
      if (bt_enter && confl_q != '1)             confl_q <= confl_q + CNT_W'(1);
    end
  end

  assign n_dec   = dec_q;
  assign n_confl = confl_q;
`else
  assign n_dec   = {CNT_W{1'b0}};
  assign n_confl = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_dpll_search_ctrl.sv
// Directed bench for dpll_search_ctrl: reactive kernel/assignment models, two DUT depths.
module tb_dpll_search_ctrl;
  import dpll_search_ctrl_pkg::*;

`ifdef DPLL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int M_KSAT = 0, M_KUNSAT = 1, M_ONE = 2, M_FLIP = 3, M_TREE = 4, M_UNDEC = 5, M_BOTH = 6;
  localparam lit_t X1  = '{neg: 1'b0, id: 4'd1};
  localparam lit_t NX1 = '{neg: 1'b1, id: 4'd1};
  localparam lit_t X2  = '{neg: 1'b0, id: 4'd2};
  localparam lit_t NX2 = '{neg: 1'b1, id: 4'd2};

  logic clock = 1'b0, reset = 1'b1, start1 = 1'b0, start2 = 1'b0;
  formula_t in_formula = '0;
  logic kern_ended = 1'b0, kern_sat = 1'b0, kern_unsat = 1'b0;
  logic asg_ended = 1'b0, asg_empty_formula = 1'b0, asg_empty_clause = 1'b0;
  formula_t kern_out = '0, asg_out = '0;

  logic busy1, done1, sat1, unsat1, ovf1, dv1, kf1, af1;
  logic busy2, done2, sat2, unsat2, ovf2, dv2, kf2, af2;
  lit_t dl1, al1, dl2, al2;
  formula_t kfm1, afm1, kfm2, afm2;
  logic [15:0] nd1, nc1, nd2, nc2;

  int mode = M_KSAT;
  bit sel = 1'b0, hold = 1'b0;
  int checks = 0, failures = 0;
  int dec_cnt = 0, done_cnt = 0, kcall_cnt = 0;
  lit_t dl_log [0:63];

  always #5 clock = ~clock;

  dpll_search_ctrl u_dut (
    .clock(clock), .reset(reset), .start(start1), .in_formula(in_formula),
    .busy(busy1), .done(done1), .sat(sat1), .unsat(unsat1), .ovf(ovf1),
    .dec_valid(dv1), .dec_lit(dl1), .kern_find(kf1), .kern_formula(kfm1),
    .kern_ended(kern_ended), .kern_sat(kern_sat), .kern_unsat(kern_unsat), .kern_out(kern_out),
    .asg_find(af1), .asg_formula(afm1), .asg_lit(al1), .asg_ended(asg_ended),
    .asg_empty_formula(asg_empty_formula), .asg_empty_clause(asg_empty_clause), .asg_out(asg_out),
    .n_dec(nd1), .n_confl(nc1)
  );

  dpll_search_ctrl #(.DEPTH(2)) u_dut2 (
    .clock(clock), .reset(reset), .start(start2), .in_formula(in_formula),
    .busy(busy2), .done(done2), .sat(sat2), .unsat(unsat2), .ovf(ovf2),
    .dec_valid(dv2), .dec_lit(dl2), .kern_find(kf2), .kern_formula(kfm2),
    .kern_ended(kern_ended), .kern_sat(kern_sat), .kern_unsat(kern_unsat), .kern_out(kern_out),
    .asg_find(af2), .asg_formula(afm2), .asg_lit(al2), .asg_ended(asg_ended),
    .asg_empty_formula(asg_empty_formula), .asg_empty_clause(asg_empty_clause), .asg_out(asg_out),
    .n_dec(nd2), .n_confl(nc2)
  );

  logic kf, af, dvs, dones, busys, sats, unsats, ovfs;
  formula_t kfm, afm, afm_c0;
  lit_t alit, dls;
  logic [15:0] nds, ncs;
  assign kf = sel ? kf2 : kf1;         assign af = sel ? af2 : af1;
  assign kfm = sel ? kfm2 : kfm1;      assign afm = sel ? afm2 : afm1;
  assign alit = sel ? al2 : al1;       assign dls = sel ? dl2 : dl1;
  assign dvs = sel ? dv2 : dv1;        assign dones = sel ? done2 : done1;
  assign busys = sel ? busy2 : busy1;  assign sats = sel ? sat2 : sat1;
  assign unsats = sel ? unsat2 : unsat1; assign ovfs = sel ? ovf2 : ovf1;
  assign nds = sel ? nd2 : nd1;        assign ncs = sel ? nc2 : nc1;

  always_comb begin
    afm_c0    = afm;
    afm_c0[0] = '0;
  end

  // Engines answer one cycle after the request with a verdict chosen by mode.
  always @(posedge clock) begin
    kern_ended <= 1'b0; kern_sat <= 1'b0; kern_unsat <= 1'b0;
    asg_ended <= 1'b0; asg_empty_formula <= 1'b0; asg_empty_clause <= 1'b0;
    if (kf) begin
      kern_ended <= 1'b1;
      kern_out   <= kfm;
      kcall_cnt  <= kcall_cnt + 1;
      if (mode == M_KSAT)   kern_sat   <= 1'b1;
      if (mode == M_KUNSAT) kern_unsat <= 1'b1;
    end
    if (af && !hold) begin
      asg_ended <= 1'b1;
      asg_out   <= afm;
      case (mode)
        M_ONE:  asg_empty_formula <= 1'b1;
        M_BOTH: begin asg_empty_formula <= 1'b1; asg_empty_clause <= 1'b1; end
        M_FLIP: if (alit == X1) asg_empty_clause <= 1'b1; else asg_empty_formula <= 1'b1;
        M_TREE: if (afm[0][0].id != '0) asg_out <= afm_c0; else asg_empty_clause <= 1'b1;
        default: ;
      endcase
    end
  end

  always @(negedge clock) begin
    if (dvs) begin
      dl_log[dec_cnt % 64] <= dls;
      dec_cnt <= dec_cnt + 1;
    end
    if (dones) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int dbase, dnbase, kbase;

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (dones) seen = 1'b1;
      else @(negedge clock);
    end
    chk("done_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge clock);
    chk("busy_end", 32'(busys), 32'd0);
    chk("one_done", 32'(done_cnt - dnbase), 32'd1);
  endtask

  task automatic run(input int m, input bit s);
    mode = m; sel = s;
    dbase = dec_cnt; dnbase = done_cnt; kbase = kcall_cnt;
    @(negedge clock);
    if (s) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0; start2 = 1'b0;
    chk("busy_after_start", 32'(busys), 32'd1);
    wait_done();
  endtask

  task automatic flags(input string tag, input bit s, input bit u, input bit o);
    chk({tag, "_sat"}, 32'(sats), 32'(s));
    chk({tag, "_unsat"}, 32'(unsats), 32'(u));
    chk({tag, "_ovf"}, 32'(ovfs), 32'(o));
  endtask

  lit_t exp_tree [6];
  bit   seen_af;

  initial begin
    in_formula[0][0] = X1;
    in_formula[1][0] = X2;
    exp_tree = '{X1, X2, NX2, NX1, X2, NX2};
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_flags", 32'({sat1, unsat1, ovf1, done1, dv1, kf1, af1}), 32'd0);
    chk("rst_lits", 32'({dl1, al1}), 32'd0);
    chk("rst_cnt", 32'({nd1, nc1}), 32'd0);

    run(M_KSAT, 1'b0);
    flags("ksat", 1, 0, 0);
    chk("ksat_kcalls", 32'(kcall_cnt - kbase), 32'd1);
    chk("ksat_decs", 32'(dec_cnt - dbase), 32'd0);
    chk("ksat_ndec", 32'(nds), 32'd0);

    run(M_KUNSAT, 1'b0);
    flags("kunsat", 0, 1, 0);
    chk("kunsat_decs", 32'(dec_cnt - dbase), 32'd0);
    chk("kunsat_nconfl", 32'(ncs), STATS ? 32'd1 : 32'd0);

    run(M_ONE, 1'b0);
    flags("one", 1, 0, 0);
    chk("one_decs", 32'(dec_cnt - dbase), 32'd1);
    chk("one_lit", 32'(dl_log[dbase % 64]), 32'(X1));
    chk("one_ndec", 32'(nds), STATS ? 32'd1 : 32'd0);
    chk("one_nconfl", 32'(ncs), 32'd0);

    run(M_BOTH, 1'b0);
    flags("both", 1, 0, 0);
    chk("both_nconfl", 32'(ncs), 32'd0);

    run(M_FLIP, 1'b0);
    flags("flip", 1, 0, 0);
    chk("flip_decs", 32'(dec_cnt - dbase), 32'd2);
    chk("flip_lit0", 32'(dl_log[dbase % 64]), 32'(X1));
    chk("flip_lit1", 32'(dl_log[(dbase + 1) % 64]), 32'(NX1));
    chk("flip_ndec", 32'(nds), STATS ? 32'd2 : 32'd0);
    chk("flip_nconfl", 32'(ncs), STATS ? 32'd1 : 32'd0);

    run(M_TREE, 1'b0);
    flags("tree", 0, 1, 0);
    chk("tree_decs", 32'(dec_cnt - dbase), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("tree_lit%0d", i), 32'(dl_log[(dbase + i) % 64]), 32'(exp_tree[i]));
    chk("tree_ndec", 32'(nds), STATS ? 32'd6 : 32'd0);
    chk("tree_nconfl", 32'(ncs), STATS ? 32'd4 : 32'd0);

    run(M_UNDEC, 1'b1);
    flags("ovf", 0, 0, 1);
    chk("ovf_decs", 32'(dec_cnt - dbase), 32'd2);
    chk("ovf_ndec", 32'(nds), STATS ? 32'd2 : 32'd0);
    chk("ovf_other_idle", 32'(busy1), 32'd0);

    // Second start while busy must not restart the search.
    mode = M_FLIP; sel = 1'b0; dbase = dec_cnt; dnbase = done_cnt;
    @(negedge clock); start1 = 1'b1;
    @(negedge clock); start1 = 1'b0;
    repeat (3) @(negedge clock);
    start1 = 1'b1;
    @(negedge clock); start1 = 1'b0;
    wait_done();
    repeat (20) @(negedge clock);
    chk("restart_done_cnt", 32'(done_cnt - dnbase), 32'd1);
    chk("restart_decs", 32'(dec_cnt - dbase), 32'd2);
    flags("restart", 1, 0, 0);

    // Reset while the assignment engine is outstanding.
    mode = M_UNDEC; sel = 1'b0; hold = 1'b1; dnbase = done_cnt;
    @(negedge clock); start1 = 1'b1;
    @(negedge clock); start1 = 1'b0;
    seen_af = 1'b0;
    for (int i = 0; i < 100 && !seen_af; i++) begin
      if (af1) seen_af = 1'b1;
      else @(negedge clock);
    end
    chk("asg_req_seen", 32'(seen_af), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_flags", 32'({busy1, done1, sat1, unsat1, ovf1, dv1, kf1, af1}), 32'd0);
    chk("mid_rst_lits", 32'({dl1, al1}), 32'd0);
    chk("mid_rst_forms", 32'({(kfm1 != '0), (afm1 != '0)}), 32'd0);
    chk("mid_rst_cnt", 32'({nd1, nc1}), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    hold = 1'b0;
    chk("mid_rst_no_done", 32'(done_cnt - dnbase), 32'd0);
    chk("mid_rst_idle", 32'(busy1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
